hazard_controller: RTL and testbench

//   Pipeline sequencer for the 5-stage core. Per cycle it produces the enable and

---
 rtl/hazard_controller_if.sv | 47 ++++
 rtl/hazard_controller.sv | 119 +++++++++++
 tb/tb_hazard_controller.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - pipeline-side signal bundle for the hazard controller
interface hazard_controller_if #(
  parameter int STALL_CNT_W = 32
);
  logic [4:0]             id_sel_rs1_i;
  logic [4:0]             id_sel_rs2_i;
  logic                   id_uses_rs1_i;
  logic                   id_uses_rs2_i;
  logic [4:0]             ex_sel_rd_i;
  logic                   ex_reg_write_i;
  logic                   ex_is_load_i;
  logic                   ex_mc_start_i;
  logic                   mc_done_i;
  logic                   ex_redirect_i;
  logic                   mem_req_i;
  logic                   mem_ready_i;
  logic                   perf_clr_i;
  logic                   pc_en_o;
  logic                   if_id_en_o;
  logic                   id_ex_en_o;
  logic                   ex_mem_en_o;
  logic                   mem_wb_en_o;
  logic                   if_id_flush_o;
  logic                   id_ex_flush_o;
  logic                   ex_mem_flush_o;
  logic                   mem_wb_flush_o;
  logic [1:0]             state_o;
  logic [STALL_CNT_W-1:0] stall_cnt_o;

  modport master (
    output id_sel_rs1_i, id_sel_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
           ex_sel_rd_i, ex_reg_write_i, ex_is_load_i, ex_mc_start_i,
           mc_done_i, ex_redirect_i, mem_req_i, mem_ready_i, perf_clr_i,
    input  pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
           if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o,
           state_o, stall_cnt_o
  );

  modport slave (
    input  id_sel_rs1_i, id_sel_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
           ex_sel_rd_i, ex_reg_write_i, ex_is_load_i, ex_mc_start_i,
           mc_done_i, ex_redirect_i, mem_req_i, mem_ready_i, perf_clr_i,
    output pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
           if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o,
           state_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - 5-stage pipeline stall/flush sequencer
module hazard_controller #(
  parameter int STALL_CNT_W = 32
) (
  input logic            clk_i,
  input logic            rst_ni,
  hazard_controller_if.slave hz
);
  typedef enum logic [1:0] {
    RUN         = 2'd0,
    MC_BUSY     = 2'd1,
    MEM_WAIT    = 2'd2,
    MEM_WAIT_MC = 2'd3
  } state_t;

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d, run_next;
  logic                   rst_done_q;
  logic                   mc_done_q, mc_done_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic                   mem_stall, mc_hold, mc_done, load_use, run_like;

  assign mem_stall = hz.mem_req_i & ~hz.mem_ready_i;
  assign mc_done   = hz.mc_done_i | mc_done_q;
  // MEM_WAIT re-evaluates as RUN once memory is ready, so it shares RUN's start term
  assign run_like  = (state_q == RUN) | (state_q == MEM_WAIT);
  assign mc_hold   = (run_like & hz.ex_mc_start_i & ~hz.mc_done_i)
                   | (((state_q == MC_BUSY) | (state_q == MEM_WAIT_MC))
                      & ~hz.mc_done_i & ~mc_done_q);
  assign load_use  = hz.ex_is_load_i & hz.ex_reg_write_i & (hz.ex_sel_rd_i != 5'd0)
                   & ((hz.id_uses_rs1_i & (hz.id_sel_rs1_i == hz.ex_sel_rd_i))
                    | (hz.id_uses_rs2_i & (hz.id_sel_rs2_i == hz.ex_sel_rd_i)));

  always_comb begin
    hz.pc_en_o        = 1'b1;
    hz.if_id_en_o     = 1'b1;
    hz.id_ex_en_o     = 1'b1;
    hz.ex_mem_en_o    = 1'b1;
    hz.mem_wb_en_o    = 1'b1;
    hz.if_id_flush_o  = 1'b0;
    hz.id_ex_flush_o  = 1'b0;
    hz.ex_mem_flush_o = 1'b0;
    hz.mem_wb_flush_o = 1'b0;
    if (!rst_done_q) begin
      hz.pc_en_o     = 1'b0;
      hz.if_id_en_o  = 1'b0;
      hz.id_ex_en_o  = 1'b0;
      hz.ex_mem_en_o = 1'b0;
      hz.mem_wb_en_o = 1'b0;
    end else if (mem_stall) begin
      hz.pc_en_o        = 1'b0;
      hz.if_id_en_o     = 1'b0;
      hz.id_ex_en_o     = 1'b0;
      hz.ex_mem_en_o    = 1'b0;
      hz.mem_wb_flush_o = 1'b1;
    end else if (mc_hold) begin
      hz.pc_en_o        = 1'b0;
      hz.if_id_en_o     = 1'b0;
      hz.id_ex_en_o     = 1'b0;
      hz.ex_mem_flush_o = 1'b1;
    end else if (hz.ex_redirect_i) begin
      // The ID instruction is wrong-path, so a redirect outranks load-use
      hz.if_id_flush_o = 1'b1;
      hz.id_ex_flush_o = 1'b1;
    end else if (load_use) begin
      hz.pc_en_o       = 1'b0;
      hz.if_id_en_o    = 1'b0;
      hz.id_ex_flush_o = 1'b1;
    end
  end

  always_comb begin
    if (mem_stall && mc_hold) run_next = MEM_WAIT_MC;
    else if (mem_stall)       run_next = MEM_WAIT;
    else if (mc_hold)         run_next = MC_BUSY;
    else                      run_next = RUN;

    state_d = state_q;
    unique case (state_q)
      RUN:         state_d = run_next;
      MEM_WAIT:    if (hz.mem_ready_i) state_d = run_next;
      MC_BUSY:     if (mem_stall) state_d = MEM_WAIT_MC;
                   else if (mc_done) state_d = RUN;
      MEM_WAIT_MC: if (hz.mem_ready_i) state_d = mc_done ? RUN : MC_BUSY;
      default:     state_d = RUN;
    endcase

    // Capture a done pulse that lands while memory holds the pipe
    if (state_d == RUN)
      mc_done_d = 1'b0;
    else if (hz.mc_done_i && ((state_q == MEM_WAIT_MC) || (state_d == MEM_WAIT_MC)))
      mc_done_d = 1'b1;
    else
      mc_done_d = mc_done_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      rst_done_q  <= 1'b0;
      mc_done_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      rst_done_q <= 1'b1;
      if (rst_done_q) begin
        state_q   <= state_d;
        mc_done_q <= mc_done_d;
      end
      if (hz.perf_clr_i)
        stall_cnt_q <= '0;
      else if (rst_done_q && !hz.pc_en_o && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
    end
  end

  assign hz.state_o     = state_q;
  assign hz.stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - vector table, corner sequences and random model check
module tb_hazard_controller;
  localparam int W = 4;
  localparam logic [8:0] C_OFF  = 9'b00000_0000;
  localparam logic [8:0] C_NORM = 9'b11111_0000;
  localparam logic [8:0] C_MEM  = 9'b00001_0001;
  localparam logic [8:0] C_MC   = 9'b00011_0010;
  localparam logic [8:0] C_RED  = 9'b11111_1100;
  localparam logic [8:0] C_LU   = 9'b00111_0100;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       mcs;
    logic       mcd;
    logic       redir;
    logic       mreq;
    logic       mrdy;
    logic       pclr;
  } in_t;

  typedef struct {
    in_t        v;
    logic [8:0] ctl;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_controller_if #(.STALL_CNT_W(W)) hz ();
  hazard_controller #(.STALL_CNT_W(W)) dut (.clk_i(clk), .rst_ni(rst_n), .hz(hz));

  int checks = 0;
  int failures = 0;

  int m_st;
  bit m_q, m_rdone;
  int m_cnt;

  function automatic in_t mk(input logic [4:0] rs1, rs2, input logic u1, u2,
                             input logic [4:0] rd, input logic rw, ld, mcs, mcd,
                             redir, mreq, mrdy, pclr);
    in_t r;
    r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.rd = rd; r.rw = rw; r.ld = ld;
    r.mcs = mcs; r.mcd = mcd; r.redir = redir; r.mreq = mreq; r.mrdy = mrdy; r.pclr = pclr;
    return r;
  endfunction

  task automatic apply(input in_t v);
    hz.id_sel_rs1_i   = v.rs1;
    hz.id_sel_rs2_i   = v.rs2;
    hz.id_uses_rs1_i  = v.u1;
    hz.id_uses_rs2_i  = v.u2;
    hz.ex_sel_rd_i    = v.rd;
    hz.ex_reg_write_i = v.rw;
    hz.ex_is_load_i   = v.ld;
    hz.ex_mc_start_i  = v.mcs;
    hz.mc_done_i      = v.mcd;
    hz.ex_redirect_i  = v.redir;
    hz.mem_req_i      = v.mreq;
    hz.mem_ready_i    = v.mrdy;
    hz.perf_clr_i     = v.pclr;
  endtask

  function automatic logic [8:0] get_ctl();
    return {hz.pc_en_o, hz.if_id_en_o, hz.id_ex_en_o, hz.ex_mem_en_o, hz.mem_wb_en_o,
            hz.if_id_flush_o, hz.id_ex_flush_o, hz.ex_mem_flush_o, hz.mem_wb_flush_o};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One cycle: drive after the edge, check mid-cycle, then step to the next edge
  task automatic cyc(input in_t v, input logic [8:0] ectl, input logic [1:0] est,
                     input int ecnt, input string nm);
    apply(v);
    #4;
    chk({nm, "_ctl"}, 32'(get_ctl()), 32'(ectl));
    chk({nm, "_state"}, 32'(hz.state_o), 32'(est));
    if (ecnt >= 0) chk({nm, "_cnt"}, 32'(hz.stall_cnt_o), ecnt[31:0]);
    @(posedge clk);
    #1;
  endtask

  // Reference: rules taken in priority order on plain integers
  function automatic void mdl(input in_t v, output logic [8:0] ctl, output int nst,
                              output bit nq);
    bit stall_mem, hold_mc, lu, done_any;
    stall_mem = v.mreq && !v.mrdy;
    done_any  = v.mcd || m_q;
    hold_mc   = ((m_st == 0 || m_st == 2) && v.mcs && !v.mcd) ||
                ((m_st == 1 || m_st == 3) && !v.mcd && !m_q);
    lu = v.ld && v.rw && (v.rd != 0) &&
         ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    if (!m_rdone)      ctl = C_OFF;
    else if (stall_mem) ctl = C_MEM;
    else if (hold_mc)  ctl = C_MC;
    else if (v.redir)  ctl = C_RED;
    else if (lu)       ctl = C_LU;
    else               ctl = C_NORM;
    nst = m_st;
    if (m_st == 0 || (m_st == 2 && v.mrdy))
      nst = stall_mem ? (hold_mc ? 3 : 2) : (hold_mc ? 1 : 0);
    else if (m_st == 1)
      nst = stall_mem ? 3 : (done_any ? 0 : 1);
    else if (m_st == 3 && v.mrdy)
      nst = done_any ? 0 : 1;
    if (nst == 0) nq = 0;
    else if (v.mcd && (m_st == 3 || nst == 3)) nq = 1;
    else nq = m_q;
  endfunction

  vec_t tbl[10];
  in_t idle, v;

  initial begin
    logic [8:0] ectl;
    int nst, exp_cnt;
    bit nq;

    idle = '0;
    tbl[0] = '{idle, C_NORM};
    tbl[1] = '{mk(5, 7, 1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0), C_LU};
    tbl[2] = '{mk(7, 9, 1, 1, 9, 1, 1, 0, 0, 0, 0, 0, 0), C_LU};
    tbl[3] = '{mk(0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0), C_NORM};
    tbl[4] = '{mk(5, 7, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0), C_NORM};
    tbl[5] = '{mk(5, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0), C_NORM};
    tbl[6] = '{mk(5, 7, 1, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0), C_NORM};
    tbl[7] = '{mk(1, 2, 1, 1, 3, 1, 0, 0, 0, 1, 0, 0, 0), C_RED};
    tbl[8] = '{mk(5, 7, 1, 1, 5, 1, 1, 0, 0, 1, 0, 0, 0), C_RED};
    tbl[9] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), C_NORM};

    rst_n = 1'b0;
    apply(idle);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cyc(idle, C_OFF, 0, 0, "reset");
    rst_n = 1'b1;
    cyc(idle, C_OFF, 0, 0, "release");
    cyc(idle, C_NORM, 0, 0, "first_run");

    // lw x5 in EX, add x6,x5,x7 in ID
    cyc(mk(5, 7, 1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0), C_LU, 0, 0, "load_use");
    cyc(idle, C_NORM, 0, 1, "after_lu");
    cyc(mk(0, 7, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0), C_NORM, 0, 1, "lu_x0");

    exp_cnt = 1;
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].v, tbl[i].ctl, 0, -1, $sformatf("vec%0d", i));
      if (!tbl[i].ctl[8]) exp_cnt++;
    end
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), C_NORM, 0, exp_cnt, "perf_clr");
    cyc(idle, C_NORM, 0, 0, "cleared");

    v = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(v, C_MC, 0, -1, "mul0");
    for (int i = 1; i < 4; i++) cyc(v, C_MC, 1, -1, "mul_busy");
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), C_NORM, 1, -1, "mul_done");
    cyc(idle, C_NORM, 0, -1, "mul_after");

    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(v, C_MEM, 0, -1, "mem1");
    cyc(v, C_MEM, 2, -1, "mem2");
    cyc(v, C_MEM, 2, -1, "mem3");
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), C_NORM, 2, -1, "mem_ready");
    cyc(idle, C_NORM, 0, -1, "mem_after");

    cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), C_MC, 0, -1, "ov_start");
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0), C_MEM, 1, -1, "ov_memstall");
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0), C_MEM, 3, -1, "ov_done_pulse");
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0), C_MEM, 3, -1, "ov_wait");
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0), C_NORM, 3, -1, "ov_ready");
    cyc(idle, C_NORM, 0, -1, "ov_after");

    v = mk(5, 7, 1, 1, 5, 1, 1, 0, 0, 1, 1, 0, 0);
    cyc(v, C_MEM, 0, -1, "red_mem1");
    cyc(v, C_MEM, 2, -1, "red_mem2");
    v.mrdy = 1'b1;
    cyc(v, C_RED, 2, -1, "red_ready");
    cyc(idle, C_NORM, 0, -1, "red_after");

    for (int i = 0; i < 800; i++) begin
      v.rs1   = 5'($urandom_range(0, 3));
      v.rs2   = 5'($urandom_range(0, 3));
      v.rd    = 5'($urandom_range(0, 3));
      v.u1    = 1'($urandom_range(0, 1));
      v.u2    = 1'($urandom_range(0, 1));
      v.rw    = ($urandom_range(0, 3) != 0);
      v.ld    = 1'($urandom_range(0, 1));
      v.mcs   = ($urandom_range(0, 3) == 0);
      v.mcd   = ($urandom_range(0, 5) == 0);
      v.redir = ($urandom_range(0, 4) == 0);
      v.mreq  = ($urandom_range(0, 2) == 0);
      v.mrdy  = !v.mreq || ($urandom_range(0, 2) == 0);
      v.pclr  = ($urandom_range(0, 40) == 0);
      rst_n   = !(i == 0 || $urandom_range(0, 150) == 0);
      apply(v);
      if (!rst_n) begin
        m_st = 0; m_q = 0; m_rdone = 0; m_cnt = 0;
      end
      #4;
      mdl(v, ectl, nst, nq);
      chk("rnd_ctl", 32'(get_ctl()), 32'(ectl));
      chk("rnd_state", 32'(hz.state_o), 32'(m_st));
      chk("rnd_cnt", 32'(hz.stall_cnt_o), 32'(m_cnt));
      if (rst_n) begin
        if (v.pclr) m_cnt = 0;
        else if (m_rdone && !ectl[8] && m_cnt < (1 << W) - 1) m_cnt++;
        if (m_rdone) begin
          m_st = nst;
          m_q  = nq;
        end
        m_rdone = 1;
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
